bcd_display_scan: RTL and testbench
===================================

Name: bcd_display_scan

Overview:
Reader side of the 4-digit BCD counter: consumes the four BCD digit buses Qdata3..Qdata0 and drives a time-multiplexed common-anode 7-segment display. Contains:
- a refresh prescaler,
- a digit-scan counter,
- a per-frame snapshot register, so all four digits shown in one frame come from the same count,
- leading-zero blanking,
- registered segment/anode outputs.

Sits beside the counter top level on the FPGA, fed directly from its Qdata outputs.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot (minimum 2).
SEG_ACTIVE_LOW, 1, 1 = segment outputs asserted low.
AN_ACTIVE_LOW, 1, 1 = anode outputs asserted low.
BLANK_LZ, 1, 1 = enable leading-zero blanking.

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous, active-high reset
Qdata3  in  4  BCD thousands digit
Qdata2  in  4  BCD hundreds digit
Qdata1  in  4  BCD tens digit
Qdata0  in  4  BCD units digit
hold  in  1  1 = freeze snapshot (display keeps last value)
seg  out  7  segments, seg[0]=a … seg[6]=g
an  out  4  anode select, an[i] = digit i
frame_tick  out  1  one-cycle pulse when the snapshot loads

Behaviour:
- Reset is synchronous and active-high on clk; it is the only reset.
- Reset values:
  - prescaler = 0, idx = 0, snapshot = 0000_0000_0000_0000.
  - load_pending = 1.
  - seg = all segments inactive; an = all anodes inactive; frame_tick = 0.
- Prescaler:
  - counts 0..SCAN_DIV-1 and wraps to 0.
  - tick = (prescaler == SCAN_DIV-1).
- Scan index idx (2 bits):
  - advances on tick, 0→1→2→3→0; holds otherwise.
- Snapshot load condition: load = load_pending | (tick & idx==3 & ~hold).
  - On load: snapshot <= {Qdata3..Qdata0}, load_pending <= 0, frame_tick = 1 in that same registered cycle.
  - hold=1 suppresses frame-boundary loads only. The post-reset load always occurs, so the display never shows stale pre-reset data.
  - hold changing mid-frame has no effect until the next frame boundary.
- Digit decode (uses snapshot values only, never live inputs):
  - 0..9 map to standard gfedcba patterns (active-high): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Values 10..15 display a dash, g only: 1000000.
- Leading-zero blanking (BLANK_LZ=1):
  - blank3 = (d3==0)
  - blank2 = blank3 & (d2==0)
  - blank1 = blank2 & (d1==0)
  - digit 0 is never blanked.
  - Invalid codes count as non-zero.
  - A blanked slot drives its anode inactive and all segments inactive.
  - BLANK_LZ=0 disables all blanking.
- Outputs:
  - seg and an are registered, updated every cycle from the current idx and snapshot.
  - Latency: one cycle from an idx change or snapshot load to the outputs.
  - Exactly one anode is active per slot (none if the slot is blanked).
  - Polarity is inverted at the output register per the *_ACTIVE_LOW parameters.
- Reset mid-scan: the next edge forces the reset values. Post-reset load occurs on the first cycle with rst=0, and slot 0 is displayed from the following cycle.

Decomposition:
- Shared package: SEG_DIGIT[0:9] pattern constants, SEG_DASH, SEG_OFF, NUM_DIGITS=4.
- One combinational sub-module, bcd_to_7seg: 4-bit in, 7-bit active-high out, dash for invalid codes. Reused by later display blocks.
- Prescaler, scan, snapshot, blanking and output registers stay in bcd_display_scan.

Test Plan:
All scenarios use SCAN_DIV=4 and both ACTIVE_LOW parameters = 1.
1. Reset: hold rst high 3 cycles with any Qdata → an=1111, seg=1111111, frame_tick=0 every cycle. First cycle after release → frame_tick=1.
2. Qdata3..0 = 9,6,7,5, hold=0 → each slot lasts 4 cycles, in this order:
   - an=1110 with seg=0010010 (5)
   - an=1101 with seg=1111000 (7)
   - an=1011 with seg=0000010 (6)
   - an=0111 with seg=0010000 (9)
   - frame_tick pulses once every 16 cycles.
3. Leading-zero blanking:
   - Qdata = 0,0,4,2 → an3 and an2 never asserted; slot 1 seg=0011001 (4), slot 0 seg=0100100 (2).
   - Qdata = 0,0,0,0 → only an0 asserted, seg=1000000 (0).
4. Hold:
   - Frame showing 1234, raise hold, change inputs to 5678 → display stays 1234 across 3 frame boundaries with no frame_tick.
   - Drop hold → 5678 appears at the next frame_tick.
5. Invalid code: Qdata = 0,0,C,3 → slot 1 seg=0111111 (dash), slot 0 seg=0110000 (3), an2/an3 blanked. With Qdata3=0, Qdata2=0, Qdata1=0, Qdata0=3 → only slot 0 shown.
6. Reset mid-scan: assert rst while idx=2 → next cycle all outputs inactive and idx=0. After release the snapshot reloads from the current inputs and slot 0 displays first.

Source files
------------

// File: rtl/bcd_display_scan_pkg.sv
// bcd_display_scan_pkg: shared 7-segment patterns (gfedcba, active-high) and display constants
package bcd_display_scan_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF = 7'b0000000;
endpackage

// File: rtl/bcd_display_scan_if.sv
// bcd_display_scan_if: digit buses + hold from the counter side (master), seg/an/frame_tick from the display side (slave)
interface bcd_display_scan_if;
  import bcd_display_scan_pkg::*;
  logic [3:0] Qdata3, Qdata2, Qdata1, Qdata0;
  logic hold;
  logic [6:0] seg;
  logic [NUM_DIGITS-1:0] an;
  logic frame_tick;
  modport master(output Qdata3, Qdata2, Qdata1, Qdata0, hold, input seg, an, frame_tick);
  modport slave(input Qdata3, Qdata2, Qdata1, Qdata0, hold, output seg, an, frame_tick);
endinterface

// File: rtl/bcd_display_scan_bcd_to_7seg.sv
// bcd_to_7seg: 4-bit code in (bcd), active-high gfedcba out (seg), dash for codes 10..15
module bcd_to_7seg
  import bcd_display_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb seg = bcd > 4'd9 ? SEG_DASH : SEG_DIGIT[bcd];
endmodule

// File: rtl/bcd_display_scan.sv
// bcd_display_scan: multiplexed 4-digit 7-seg driver with frame snapshot and leading-zero blanking; ports clk, rst, bus (slave: Qdata3..0, hold in; seg, an, frame_tick out)
module bcd_display_scan
  import bcd_display_scan_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ = 1'b1
) (
  input logic clk,
  input logic rst,
  bcd_display_scan_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  logic [PW-1:0] presc;
  logic [1:0] idx;
  logic [NUM_DIGITS-1:0][3:0] snap;
  logic load_pending, tick, load;
  logic [NUM_DIGITS-1:0] blank, an_n;
  logic [6:0] seg_hi, seg_n;
  bcd_to_7seg u_dec (.bcd(snap[idx]), .seg(seg_hi));
  always_comb begin
    tick = presc == PW'(SCAN_DIV - 1);
    load = load_pending || (tick && idx == 2'd3 && !bus.hold);
    blank[3] = BLANK_LZ && snap[3] == 4'd0;
    blank[2] = blank[3] && snap[2] == 4'd0;
    blank[1] = blank[2] && snap[1] == 4'd0;
    blank[0] = 1'b0;
    seg_n = blank[idx] ? SEG_OFF : seg_hi;
    an_n = blank[idx] ? '0 : NUM_DIGITS'(1) << idx;
  end
  always_ff @(posedge clk)
    if (rst) begin
      presc <= '0;
      idx <= 2'd0;
      snap <= '0;
      load_pending <= 1'b1;
      bus.seg <= {7{SEG_ACTIVE_LOW}};
      bus.an <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      bus.frame_tick <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= idx + 2'd1;
      if (load) snap <= {bus.Qdata3, bus.Qdata2, bus.Qdata1, bus.Qdata0};
      load_pending <= 1'b0;
      bus.seg <= seg_n ^ {7{SEG_ACTIVE_LOW}};
      bus.an <= an_n ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
      bus.frame_tick <= load;
    end
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: directed stimulus, per-cycle arithmetic display model plus literal slot checks
module tb_bcd_display_scan;
  localparam int D = 4;
  localparam int F = 4 * D;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int k = 0;
  int m_idx = 0;
  bit mvalid = 1'b0;
  logic [15:0] m_snap;
  logic [6:0] e_seg;
  logic [3:0] e_an;
  logic e_ft;
  bcd_display_scan_if bus ();
  bcd_display_scan #(.SCAN_DIV(D), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [6:0] pat(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction
  function automatic logic [10:0] disp(input int i, input logic [15:0] s);
    int top;
    top = 0;
    for (int j = 1; j < 4; j++) if (s[4*j +: 4] != 4'd0) top = j;
    if (i > top) return {4'hf, 7'h7f};
    return {~(4'b0001 << i), ~pat(s[4*i +: 4])};
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      k = 0;
      m_idx = 0;
      m_snap = '0;
      {e_an, e_seg} = {4'hf, 7'h7f};
      e_ft = 1'b0;
    end else begin
      {e_an, e_seg} = disp((k / D) % 4, m_snap);
      e_ft = (k == 0) || (k % F == F - 1 && !bus.hold);
      if (e_ft) m_snap = {bus.Qdata3, bus.Qdata2, bus.Qdata1, bus.Qdata0};
      k++;
      m_idx = (k / D) % 4;
    end
    mvalid = 1'b1;
  end
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (mvalid) begin
      check("model_seg", {9'd0, bus.seg}, {9'd0, e_seg});
      check("model_an", {12'd0, bus.an}, {12'd0, e_an});
      check("model_ft", {15'd0, bus.frame_tick}, {15'd0, e_ft});
    end
  task automatic set_q(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    {bus.Qdata3, bus.Qdata2, bus.Qdata1, bus.Qdata0} = {a, b, c, d};
    repeat (40) @(negedge clk);
  endtask
  task automatic lit_slot(input string name, input logic [3:0] a, input logic [6:0] s);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = bus.an == a;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s: anode %b never seen, last %b", name, a, bus.an);
    end else check(name, {9'd0, bus.seg}, {9'd0, s});
  endtask
  task automatic count(input int n, output int ft, output int a3, output int a2, output int a1);
    {ft, a3, a2, a1} = '0;
    repeat (n) begin
      @(negedge clk);
      ft += int'(bus.frame_tick);
      a3 += int'(!bus.an[3]);
      a2 += int'(!bus.an[2]);
      a1 += int'(!bus.an[1]);
    end
  endtask
  initial begin
    int ft, a3, a2, a1;
    bit ok;
    {bus.Qdata3, bus.Qdata2, bus.Qdata1, bus.Qdata0} = {4'd9, 4'd6, 4'd7, 4'd5};
    bus.hold = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_an", {12'd0, bus.an}, 16'hf);
      check("rst_seg", {9'd0, bus.seg}, 16'h7f);
      check("rst_ft", {15'd0, bus.frame_tick}, 16'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ft", {15'd0, bus.frame_tick}, 16'd1);
    @(negedge clk);
    lit_slot("d0_5", 4'b1110, 7'b0010010);
    lit_slot("d1_7", 4'b1101, 7'b1111000);
    lit_slot("d2_6", 4'b1011, 7'b0000010);
    lit_slot("d3_9", 4'b0111, 7'b0010000);
    count(32, ft, a3, a2, a1);
    check("ft_per_frame", 16'(ft), 16'd2);
    set_q(4'd0, 4'd0, 4'd4, 4'd2);
    count(16, ft, a3, a2, a1);
    check("lz_an3", 16'(a3), 16'd0);
    check("lz_an2", 16'(a2), 16'd0);
    lit_slot("lz_d1_4", 4'b1101, 7'b0011001);
    lit_slot("lz_d0_2", 4'b1110, 7'b0100100);
    set_q(4'd0, 4'd0, 4'd0, 4'd0);
    count(16, ft, a3, a2, a1);
    check("zero_an321", 16'(a3 + a2 + a1), 16'd0);
    lit_slot("zero_d0", 4'b1110, 7'b1000000);
    set_q(4'd1, 4'd2, 4'd3, 4'd4);
    lit_slot("h_d0_4", 4'b1110, 7'b0011001);
    bus.hold = 1'b1;
    {bus.Qdata3, bus.Qdata2, bus.Qdata1, bus.Qdata0} = {4'd5, 4'd6, 4'd7, 4'd8};
    count(48, ft, a3, a2, a1);
    check("hold_no_ft", 16'(ft), 16'd0);
    lit_slot("hold_d0", 4'b1110, 7'b0011001);
    lit_slot("hold_d3", 4'b0111, 7'b1111001);
    bus.hold = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.frame_tick;
    end
    check("unhold_ft_seen", {15'd0, ok}, 16'd1);
    @(negedge clk);
    check("unhold_an", {12'd0, bus.an}, 16'b1110);
    check("unhold_seg8", {9'd0, bus.seg}, 16'b0000000);
    set_q(4'd0, 4'd0, 4'hc, 4'd3);
    lit_slot("inv_dash", 4'b1101, 7'b0111111);
    lit_slot("inv_d0_3", 4'b1110, 7'b0110000);
    count(16, ft, a3, a2, a1);
    check("inv_an32", 16'(a3 + a2), 16'd0);
    set_q(4'd0, 4'd0, 4'd0, 4'd3);
    count(16, ft, a3, a2, a1);
    check("only0_an321", 16'(a3 + a2 + a1), 16'd0);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = m_idx == 2;
    end
    check("idx2_reached", {15'd0, ok}, 16'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_an", {12'd0, bus.an}, 16'hf);
    check("mid_rst_seg", {9'd0, bus.seg}, 16'h7f);
    check("mid_rst_ft", {15'd0, bus.frame_tick}, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rel_ft", {15'd0, bus.frame_tick}, 16'd1);
    @(negedge clk);
    check("mid_slot0_an", {12'd0, bus.an}, 16'b1110);
    check("mid_slot0_seg", {9'd0, bus.seg}, 16'b0110000);
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
